// File: rtl/wishbone_regfile_slave.sv
// Wishbone register-file slave: DEPTH-word window at BASE_ADDR, wait states, incrementing bursts, byte lanes.
// Define WB_REGFILE_ERR_EN to flag out-of-range strobes on err_o; otherwise err_o is tied low.
module wishbone_regfile_slave #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int DATA_BYTES    = 1,
   parameter int DEPTH         = 16,
   parameter int BASE_ADDR     = 0,
   parameter int WAIT_STATES   = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [ADDRESS_WIDTH-1:0] adr_i,
   input  logic [DATA_WIDTH-1:0]    dat_i,
   output logic [DATA_WIDTH-1:0]    dat_o,
   input  logic                     we_i,
   input  logic [DATA_BYTES-1:0]    sel_i,
   input  logic                     stb_i,
   input  logic                     cyc_i,
   input  logic [2:0]               cti_i,
   output logic                     ack_o,
   output logic                     err_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [PW-1:0]            ptr_q, ptr_d, ptr_inc;
   logic [ADDRESS_WIDTH-1:0] off;
   logic                     in_range, hit, ld_rd, wr_en;
   logic [DATA_WIDTH-1:0]    mem [DEPTH];

   assign off      = adr_i - ADDRESS_WIDTH'(BASE_ADDR);
   assign in_range = off < ADDRESS_WIDTH'(DEPTH);
   assign hit      = cyc_i & stb_i & in_range;
   // Burst pointer wraps inside the file even when DEPTH is not a power of two.
   assign ptr_inc  = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ack_o   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_o   <= (state_d == S_ACK) || (state_d == S_BURST);
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      ld_rd   = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               ptr_d = off[PW-1:0];
               if (WAIT_STATES == 0) begin
                  state_d = S_ACK;
                  ld_rd   = ~we_i;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!hit) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_ACK;
               ptr_d   = off[PW-1:0];
               ld_rd   = ~we_i;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            // ACK and BURST: a beat completes only while the master still strobes.
            if (!(cyc_i && stb_i)) begin
               state_d = S_IDLE;
            end else begin
               wr_en = we_i;
               if (cti_i == 3'b010) begin
                  state_d = S_BURST;
                  ptr_d   = ptr_inc;
                  ld_rd   = ~we_i;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: the file is cleared on reset, so it is built from flops rather than a RAM macro.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         dat_o <= '0;
         ptr_q <= '0;
      end else begin
         if (wr_en) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
               if (sel_i[b]) mem[ptr_q][8*b +: 8] <= dat_i[8*b +: 8];
            end
         end
         if (ld_rd) dat_o <= mem[ptr_d];
         ptr_q <= ptr_d;
      end
   end

`ifdef WB_REGFILE_ERR_EN
   logic err_d;
   // Raised only from IDLE, where the next state is IDLE too, so ack_o and err_o never coincide.
   assign err_d = (state_q == S_IDLE) & cyc_i & stb_i & ~in_range;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) err_o <= 1'b0;
      else          err_o <= err_d;
   end
`else
   assign err_o = 1'b0;
`endif

endmodule
